// File: rtl/qoi_pkg.sv
// Shared constants and types for the QOI pixel encoder.
// Covers register map, chunk tags, run limit and the RGBA pixel struct.
package qoi_pkg;

    typedef enum logic [2:0] {
        ADDR_R        = 3'd0,
        ADDR_G        = 3'd1,
        ADDR_B        = 3'd2,
        ADDR_A        = 3'd3,
        ADDR_CTRL     = 3'd4,
        ADDR_OUT_CNT  = 3'd5,
        ADDR_OUT_DATA = 3'd6,
        ADDR_RUN      = 3'd7
    } reg_addr_e;

    localparam logic [7:0] OP_INDEX = 8'h00;
    localparam logic [7:0] OP_DIFF  = 8'h40;
    localparam logic [7:0] OP_LUMA  = 8'h80;
    localparam logic [7:0] OP_RUN   = 8'hC0;
    localparam logic [7:0] OP_RGB   = 8'hFE;
    localparam logic [7:0] OP_RGBA  = 8'hFF;

    localparam logic [5:0] RUN_MAX   = 6'd62;
    localparam int         BUF_DEPTH = 6;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } pixel_t;

    localparam pixel_t PIXEL_START = 32'h0000_00FF;

    // Run chunks store the length biased by one.
    function automatic logic [7:0] run_byte(input logic [5:0] run);
        return OP_RUN | {2'b00, run - 6'd1};
    endfunction

endpackage

// File: rtl/qoi_if.sv
// Register bus between a host and the QOI encoder.
interface qoi_if;
    logic       cs;
    logic       we;
    logic [2:0] addr;
    logic [7:0] data_i;
    logic [7:0] data_o;

    modport master (output cs, we, addr, data_i, input data_o);
    modport slave  (input cs, we, addr, data_i, output data_o);
endinterface

// File: rtl/qoi_hash.sv
// Combinational QOI colour-index hash: (3R + 5G + 7B + 11A) mod 64.
module qoi_hash
    import qoi_pkg::*;
(
    input  pixel_t     px,
    output logic [5:0] idx
);
    // Only the low six bits of each product survive the mod 64.
    assign idx = px.r[5:0] * 6'd3 + px.g[5:0] * 6'd5 + px.b[5:0] * 6'd7 + px.a[5:0] * 6'd11;
endmodule

// File: rtl/qoi.sv
// Register-mapped QOI encoder: one pixel per commit, up to six output bytes buffered.
// Define QOI_INDEX_EN to build the 64-entry colour index table and emit INDEX chunks.
module qoi
    import qoi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    qoi_if.slave bus
);
    pixel_t                      cur_px, prev_px, new_px;
    logic [5:0]                  run, run_nxt, hash;
    logic                        ovf, idx_hit, emit_px;
    logic [BUF_DEPTH-1:0][7:0]   out_buf, enc_buf;
    logic [2:0]                  out_cnt, enc_cnt, chunk_len;
    logic [4:0][7:0]             chunk;
    logic [7:0]                  dr, dg, db, dr2, dg2, db2, dg32, rd_data;
    logic [9:0]                  vr, vb;
    logic                        wr, rd, commit_ok, enc_rst, same_a, diff_ok, luma_ok;

    assign wr        = bus.cs & bus.we;
    assign rd        = bus.cs & ~bus.we;
    assign commit_ok = wr && (bus.addr == ADDR_A) && (out_cnt == 3'd0);
    assign enc_rst   = wr && (bus.addr == ADDR_CTRL) && bus.data_i[0];
    assign new_px    = {cur_px.r, cur_px.g, cur_px.b, bus.data_i};

`ifdef QOI_INDEX_EN
    pixel_t idx_tab [64];

    qoi_hash u_hash (.px(new_px), .idx(hash));
    assign idx_hit = (idx_tab[hash] == new_px);

    always_ff @(posedge clk) begin
        if (rst || enc_rst) begin
            for (int i = 0; i < 64; i++) idx_tab[i] <= '0;
        end else if (commit_ok && emit_px) begin
            idx_tab[hash] <= new_px;
        end
    end
`else
    assign hash    = '0;
    assign idx_hit = 1'b0;
`endif

    // Biased differences: a component fits a field when its biased value has no high bits.
    assign dr     = new_px.r - prev_px.r;
    assign dg     = new_px.g - prev_px.g;
    assign db     = new_px.b - prev_px.b;
    assign dr2    = dr + 8'd2;
    assign dg2    = dg + 8'd2;
    assign db2    = db + 8'd2;
    assign dg32   = dg + 8'd32;
    assign vr     = {{2{dr[7]}}, dr} - {{2{dg[7]}}, dg} + 10'd8;
    assign vb     = {{2{db[7]}}, db} - {{2{dg[7]}}, dg} + 10'd8;
    assign same_a = (new_px.a == prev_px.a);
    assign diff_ok = (dr2[7:2] == 6'd0) && (dg2[7:2] == 6'd0) && (db2[7:2] == 6'd0);
    assign luma_ok = (dg32[7:6] == 2'd0) && (vr[9:4] == 6'd0) && (vb[9:4] == 6'd0);

    always_comb begin
        chunk     = '0;
        chunk_len = 3'd0;
        if (idx_hit) begin
            chunk[0]  = OP_INDEX | {2'b00, hash};
            chunk_len = 3'd1;
        end else if (same_a && diff_ok) begin
            chunk[0]  = OP_DIFF | {2'b00, dr2[1:0], dg2[1:0], db2[1:0]};
            chunk_len = 3'd1;
        end else if (same_a && luma_ok) begin
            chunk[0]  = OP_LUMA | {2'b00, dg32[5:0]};
            chunk[1]  = {vr[3:0], vb[3:0]};
            chunk_len = 3'd2;
        end else if (same_a) begin
            chunk[3:0] = {new_px.b, new_px.g, new_px.r, OP_RGB};
            chunk_len  = 3'd4;
        end else begin
            chunk      = {new_px.a, new_px.b, new_px.g, new_px.r, OP_RGBA};
            chunk_len  = 3'd5;
        end
    end

    // Pending run bytes always precede the chunk of a differing pixel.
    always_comb begin
        enc_buf = '0;
        enc_cnt = 3'd0;
        run_nxt = run;
        emit_px = 1'b0;
        if (new_px == prev_px) begin
            if (run == RUN_MAX - 6'd1) begin
                enc_buf[0] = run_byte(RUN_MAX);
                enc_cnt    = 3'd1;
                run_nxt    = 6'd0;
            end else begin
                run_nxt = run + 6'd1;
            end
        end else begin
            emit_px = 1'b1;
            run_nxt = 6'd0;
            if (run != 6'd0) begin
                enc_buf = {chunk, run_byte(run)};
                enc_cnt = chunk_len + 3'd1;
            end else begin
                enc_buf = {8'h00, chunk};
                enc_cnt = chunk_len;
            end
        end
    end

    // A nonzero run implies an empty buffer, so a flush always lands in slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_px  <= '0;
            ovf     <= 1'b0;
            prev_px <= PIXEL_START;
            run     <= 6'd0;
            out_buf <= '0;
            out_cnt <= 3'd0;
        end else if (wr) begin
            case (reg_addr_e'(bus.addr))
                ADDR_R: cur_px.r <= bus.data_i;
                ADDR_G: cur_px.g <= bus.data_i;
                ADDR_B: cur_px.b <= bus.data_i;
                ADDR_A: begin
                    if (out_cnt != 3'd0) begin
                        ovf <= 1'b1;
                    end else begin
                        cur_px.a <= bus.data_i;
                        prev_px  <= new_px;
                        run      <= run_nxt;
                        out_buf  <= enc_buf;
                        out_cnt  <= enc_cnt;
                    end
                end
                ADDR_CTRL: begin
                    if (bus.data_i[2]) ovf <= 1'b0;
                    if (bus.data_i[0]) begin
                        prev_px <= PIXEL_START;
                        run     <= 6'd0;
                        out_buf <= '0;
                        out_cnt <= 3'd0;
                    end else if (bus.data_i[1] && run != 6'd0) begin
                        out_buf[0] <= run_byte(run);
                        out_cnt    <= 3'd1;
                        run        <= 6'd0;
                    end
                end
                default: ;
            endcase
        end else if (rd && bus.addr == ADDR_OUT_DATA && out_cnt != 3'd0) begin
            out_buf <= {8'h00, out_buf[BUF_DEPTH-1:1]};
            out_cnt <= out_cnt - 3'd1;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_addr_e'(bus.addr))
            ADDR_R:        rd_data = cur_px.r;
            ADDR_G:        rd_data = cur_px.g;
            ADDR_B:        rd_data = cur_px.b;
            ADDR_A:        rd_data = cur_px.a;
            ADDR_CTRL:     rd_data = {run != 6'd0, ovf, 3'b000, out_cnt};
            ADDR_OUT_CNT:  rd_data = {5'b00000, out_cnt};
            ADDR_OUT_DATA: rd_data = (out_cnt != 3'd0) ? out_buf[0] : 8'h00;
            ADDR_RUN:      rd_data = {2'b00, run};
            default:       rd_data = '0;
        endcase
    end

    assign bus.data_o = rd_data;

endmodule

// File: tb/tb_qoi.sv
// Self-checking bench for qoi: directed vectors plus randomized traffic against a queue-based model.
module tb_qoi;
    import qoi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qoi_if bus ();
    qoi dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef QOI_INDEX_EN
    localparam logic [7:0] REVISIT_EXP = 8'h09;
`else
    localparam logic [7:0] REVISIT_EXP = 8'h5D;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integers and a byte queue.
    int         m_cur [4];
    int         m_prev [4];
    int         m_run;
    bit         m_ovf;
    int         m_tab [64];
    logic [7:0] m_q [$];

    function automatic int sdiff(input int x, input int y);
        int d;
        d = (x - y) & 255;
        return (d > 127) ? d - 256 : d;
    endfunction

    function automatic int pack_px(input int r, input int g, input int b, input int a);
        return (r << 24) | (g << 16) | (b << 8) | a;
    endfunction

    function automatic void model_enc_reset();
        m_prev = '{0, 0, 0, 255};
        m_run  = 0;
        foreach (m_tab[i]) m_tab[i] = 0;
        m_q.delete();
    endfunction

    function automatic void model_flush();
        if (m_run > 0) begin
            m_q.push_back(8'(192 + m_run - 1));
            m_run = 0;
        end
    endfunction

    function automatic void model_commit(input int a);
        int r, g, b, h, dr, dg, db;
        bit hit;
        if (m_q.size() != 0) begin
            m_ovf = 1'b1;
            return;
        end
        m_cur[3] = a;
        r = m_cur[0]; g = m_cur[1]; b = m_cur[2];
        if (r == m_prev[0] && g == m_prev[1] && b == m_prev[2] && a == m_prev[3]) begin
            m_run++;
            if (m_run == 62) begin
                m_q.push_back(8'hFD);
                m_run = 0;
            end
            return;
        end
        model_flush();
        h   = (r * 3 + g * 5 + b * 7 + a * 11) % 64;
        hit = 1'b0;
`ifdef QOI_INDEX_EN
        hit      = (m_tab[h] == pack_px(r, g, b, a));
        m_tab[h] = pack_px(r, g, b, a);
`endif
        dr = sdiff(r, m_prev[0]);
        dg = sdiff(g, m_prev[1]);
        db = sdiff(b, m_prev[2]);
        if (hit) begin
            m_q.push_back(8'(h));
        end else if (a != m_prev[3]) begin
            m_q.push_back(8'hFF); m_q.push_back(8'(r)); m_q.push_back(8'(g));
            m_q.push_back(8'(b)); m_q.push_back(8'(a));
        end else if (dr >= -2 && dr <= 1 && dg >= -2 && dg <= 1 && db >= -2 && db <= 1) begin
            m_q.push_back(8'(64 + (dr + 2) * 16 + (dg + 2) * 4 + (db + 2)));
        end else if (dg >= -32 && dg <= 31 && dr - dg >= -8 && dr - dg <= 7 &&
                     db - dg >= -8 && db - dg <= 7) begin
            m_q.push_back(8'(128 + dg + 32));
            m_q.push_back(8'((dr - dg + 8) * 16 + (db - dg + 8)));
        end else begin
            m_q.push_back(8'hFE); m_q.push_back(8'(r)); m_q.push_back(8'(g)); m_q.push_back(8'(b));
        end
        m_prev = '{r, g, b, a};
    endfunction

    function automatic logic [7:0] model_read(input int a);
        case (a)
            0, 1, 2, 3: return 8'(m_cur[a]);
            4:          return {m_run > 0, m_ovf, 3'b000, 3'(m_q.size())};
            5:          return 8'(m_q.size());
            6:          return (m_q.size() != 0) ? m_q[0] : 8'h00;
            default:    return 8'(m_run);
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    task automatic apply_write(input int a, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 3'(a); bus.data_i = d;
        @(posedge clk);
        #1 bus.cs = 1'b0; bus.we = 1'b0;
        case (a)
            0, 1, 2: m_cur[a] = int'(d);
            3:       model_commit(int'(d));
            4: begin
                if (d[2]) m_ovf = 1'b0;
                if (d[0]) model_enc_reset();
                else if (d[1]) model_flush();
            end
            default: ;
        endcase
    endtask

    task automatic apply_read(input int a, output logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 3'(a);
        #1 d = bus.data_o;
        @(posedge clk);
        #1 bus.cs = 1'b0;
        if (a == 6 && m_q.size() != 0) void'(m_q.pop_front());
    endtask

    task automatic read_check(input int a, input string tag);
        logic [7:0] exp, d;
        exp = model_read(a);
        apply_read(a, d);
        check_output(tag, d, exp);
    endtask

    task automatic commit_px(input int r, input int g, input int b, input int a);
        apply_write(0, 8'(r));
        apply_write(1, 8'(g));
        apply_write(2, 8'(b));
        apply_write(3, 8'(a));
    endtask

    task automatic expect_out(input string tag, input int n, input logic [7:0] e [6]);
        logic [7:0] d;
        apply_read(5, d);
        check_output({tag, "_cnt"}, d, 8'(n));
        for (int i = 0; i < n; i++) begin
            apply_read(6, d);
            check_output($sformatf("%s_byte%0d", tag, i), d, e[i]);
        end
        apply_read(5, d);
        check_output({tag, "_empty"}, d, 8'h00);
    endtask

    task automatic drain_check();
        int n;
        read_check(5, "drain_cnt");
        n = m_q.size();
        for (int i = 0; i < n; i++) read_check(6, "drain_byte");
        read_check(5, "drain_empty");
    endtask

    // Reset asserted during a write to R: the reset must win.
    task automatic do_reset();
        @(negedge clk);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = 3'd0; bus.data_i = 8'h55;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; bus.cs = 1'b0; bus.we = 1'b0;
        m_cur = '{0, 0, 0, 0};
        m_ovf = 1'b0;
        model_enc_reset();
    endtask

    initial begin
        logic [7:0] d;
        int sel, mode, r, g, b, a, dgv;
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_i = '0;
        rst = 1'b1;
        do_reset();

        apply_read(0, d); check_output("rst_r", d, 8'h00);
        apply_read(3, d); check_output("rst_a", d, 8'h00);
        apply_read(4, d); check_output("rst_status", d, 8'h00);
        apply_read(5, d); check_output("rst_cnt", d, 8'h00);
        apply_read(6, d); check_output("rst_data", d, 8'h00);
        apply_read(7, d); check_output("rst_run", d, 8'h00);

        commit_px(10, 20, 30, 255);
        expect_out("rgb", 4, '{8'hFE, 8'h0A, 8'h14, 8'h1E, 8'h00, 8'h00});
        commit_px(11, 19, 31, 255);
        expect_out("diff", 1, '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        commit_px(10, 20, 30, 255);
        expect_out("revisit", 1, '{REVISIT_EXP, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        commit_px(20, 30, 40, 255);
        expect_out("luma", 2, '{8'hAA, 8'h88, 8'h00, 8'h00, 8'h00, 8'h00});

        do_reset();
        for (int i = 0; i < 61; i++) commit_px(0, 0, 0, 255);
        apply_read(7, d); check_output("run61", d, 8'd61);
        commit_px(0, 0, 0, 255);
        expect_out("run_max", 1, '{8'hFD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        commit_px(0, 0, 0, 255);
        apply_read(7, d); check_output("run_after_max", d, 8'd1);
        apply_read(4, d); check_output("status_run", d, 8'h80);
        apply_write(4, 8'h02);
        expect_out("flush", 1, '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        apply_read(7, d); check_output("run_flushed", d, 8'd0);

        do_reset();
        for (int i = 0; i < 3; i++) commit_px(0, 0, 0, 255);
        commit_px(10, 20, 30, 128);
        expect_out("run_rgba", 6, '{8'hC2, 8'hFF, 8'h0A, 8'h14, 8'h1E, 8'h80});

        do_reset();
        commit_px(10, 20, 30, 255);
        commit_px(1, 2, 3, 99);
        apply_read(5, d); check_output("ovf_cnt", d, 8'd4);
        apply_read(4, d); check_output("ovf_status", d, 8'h44);
        apply_read(3, d); check_output("ovf_a_kept", d, 8'd255);
        apply_write(4, 8'h04);
        apply_read(4, d); check_output("ovf_clear", d, 8'h04);
        apply_read(6, d); check_output("ovf_head", d, 8'hFE);
        apply_write(4, 8'h03);
        apply_read(5, d); check_output("encrst_cnt", d, 8'd0);
        apply_read(7, d); check_output("encrst_run", d, 8'd0);
        apply_read(0, d); check_output("encrst_r_kept", d, 8'd1);

        for (int it = 0; it < 400; it++) begin
            sel = $urandom_range(0, 11);
            if (sel <= 6) begin
                if (m_q.size() != 0 && $urandom_range(0, 3) != 0) drain_check();
                mode = $urandom_range(0, 5);
                r = m_prev[0]; g = m_prev[1]; b = m_prev[2]; a = m_prev[3];
                case (mode)
                    0: ;
                    1: begin
                        r = (r + $urandom_range(0, 3) - 2) & 255;
                        g = (g + $urandom_range(0, 3) - 2) & 255;
                        b = (b + $urandom_range(0, 3) - 2) & 255;
                    end
                    2: begin
                        dgv = $urandom_range(0, 63) - 32;
                        r = (r + dgv + $urandom_range(0, 15) - 8) & 255;
                        g = (g + dgv) & 255;
                        b = (b + dgv + $urandom_range(0, 15) - 8) & 255;
                    end
                    3: begin
                        r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
                    end
                    4: begin
                        r = 40 * $urandom_range(0, 3); g = 7; b = 200; a = 255;
                    end
                    default: begin
                        r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
                        a = $urandom_range(0, 1) ? 255 : $urandom_range(0, 255);
                    end
                endcase
                commit_px(r, g, b, a);
                read_check(4, "rnd_status");
            end else if (sel <= 8) begin
                drain_check();
            end else if (sel == 9) begin
                read_check(6, "rnd_pop");
            end else if (sel == 10) begin
                d = 8'($urandom_range(0, 7));
                if ($urandom_range(0, 3) != 0) d[0] = 1'b0;
                apply_write(4, d);
                read_check(4, "rnd_ctrl");
            end else begin
                if ($urandom_range(0, 1) != 0) apply_write($urandom_range(5, 7), 8'($urandom_range(0, 255)));
                read_check($urandom_range(0, 7), "rnd_reg");
            end
        end
        drain_check();
        read_check(7, "final_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qoi.md
QOI -- requirements
Module: qoi

Interface
REQ-001 No parameters; constants come from qoi_pkg.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 cs  input  1  chip select; register access only when high.
REQ-005 we  input  1  1 = write data_i to addr at clock edge; 0 = read.
REQ-006 data_i  input  8  write data.
REQ-007 data_o  output  8  combinational read data for addr, valid whenever addr is stable, independent of cs.
REQ-008 addr  input  3  register select: 0 R, 1 G, 2 B, 3 A+COMMIT, 4 CTRL/STATUS, 5 OUT_CNT, 6 OUT_DATA, 7 RUN.

Function
REQ-009 Regs 0-3 are read/write pixel component registers; a write to addr 3 stores A and, that edge, encodes pixel {R,G,B,A} as one QOI step, results visible next cycle.
REQ-010 Encoder state: prev pixel, run counter 0..62, 64-entry RGBA index table, output buffer of up to 6 bytes.
REQ-011 Pixel equal to prev: run++; when run reaches 62, append 0xFD and clear run; nothing else emitted.
REQ-012 Pixel differs: if run>0, first append 0xC0|(run-1) and clear run; then append one chunk by priority INDEX, DIFF, LUMA, RGB, RGBA.
REQ-013 hash = (R*3+G*5+B*7+A*11) mod 64; INDEX if table[hash]==pixel: byte 0x00|hash.
REQ-014 Differences dr,dg,db are 8-bit wrapping, signed; DIFF/LUMA/RGB only when A equals prev A.
REQ-015 DIFF if dr,dg,db in -2..1: 0x40|(dr+2)<<4|(dg+2)<<2|(db+2).
REQ-016 LUMA if dg in -32..31 and dr-dg, db-dg in -8..7: 0x80|(dg+32), then (dr-dg+8)<<4|(db-dg+8).
REQ-017 RGB: 0xFE,R,G,B; RGBA (alpha changed): 0xFF,R,G,B,A.
REQ-018 Every non-run pixel writes table[hash]=pixel and becomes prev.
REQ-019 COMMIT while OUT_CNT!=0 is ignored (no state change) and sets sticky OVF.
REQ-020 CTRL write: bit0 encoder reset (as REQ-026, pixel regs kept), bit1 flush (append run byte if run>0, clear run), bit2 clear OVF; bit0 wins over bit1 if both set.
REQ-021 STATUS read: [2:0] OUT_CNT, [6] OVF, [7] run>0, others 0.
REQ-022 OUT_CNT reads 0..6; OUT_DATA reads head byte, and a read (cs & ~we) pops it at that edge; empty reads 0, no pop.
REQ-023 RUN reads current run count; writes to 5,6,7 ignored.

Reset
REQ-024 rst overrides all accesses in the same cycle.
REQ-025 Pixel regs 0; OVF 0; data_o follows from reset state (addr 3 reads 0).
REQ-026 prev = (0,0,0,255), run 0, table all zero, buffer empty.

Configuration
REQ-027 Macro QOI_INDEX_EN: defined -> index table and INDEX op as above; undefined -> no table, INDEX never emitted, priority DIFF first.

Structure
REQ-028 qoi_pkg holds register addresses, opcode/tag constants (0x00,0x40,0x80,0xC0,0xFE,0xFF), run max 62, pixel struct typedef.
REQ-029 One sub-module qoi_hash: combinational pixel -> 6-bit index.

Verification
REQ-030 After reset commit 10,20,30,255 -> OUT_CNT 4, OUT_DATA reads FE 0A 14 1E, then OUT_CNT 0.
REQ-031 Then 11,19,31,255 -> 0x77; then 10,20,30,255 -> 0x09 (index); then 20,30,40,255 -> 0xAA 0x88.
REQ-032 From reset, 63 commits of 0,0,0,255 -> 0xFD after 62nd, RUN=1; flush -> 0xC0.
REQ-033 Run 3 then 10,20,30,128 -> C2 FF 0A 14 1E 80 (OUT_CNT 6).
REQ-034 Commit with OUT_CNT=4 -> ignored, STATUS bit6=1; CTRL bit2 clears it; CTRL bit0 mid-buffer -> OUT_CNT 0, RUN 0.
